conf_int_add_result_acc: RTL

Windowed accumulator that sits directly downstream of `conf_int_add__noFF__multiple_add` and consumes its `c` result stream. It sums a fixed window of signed adder results and presents the window sum and sample count on a valid/ready output port. Accumulated window sums are the basis for comparing approximate and exact adder configurations over long runs without dumping every sample.

---
 rtl/conf_int_add_result_acc.sv | 121 ++++++++++++
 1 files changed

// File: rtl/conf_int_add_result_acc.sv
// conf_int_add_result_acc
// Windowed accumulator for the signed result stream of the approximate/exact
// adder. It sums WINDOW samples, or fewer when flush closes the window early,
// and offers {out_sum, out_count, out_ovf} on a valid/ready port.
// Optional build macro: CONF_INT_ADD_RESULT_ACC_SAT_EN. When it is defined,
// the accumulator saturates and reports overflow on out_ovf. When it is not
// defined, the accumulator wraps and out_ovf stays 0.
module conf_int_add_result_acc #(
  parameter int OP_BITWIDTH  = 32,
  parameter int ACC_BITWIDTH = 40,
  parameter int WINDOW       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [OP_BITWIDTH-1:0]  in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_BITWIDTH-1:0] out_sum,
  output logic [15:0]             out_count,
  output logic                    out_ovf
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [15:0] WIN = 16'(WINDOW);

`ifdef CONF_INT_ADD_RESULT_ACC_SAT_EN
  localparam logic [ACC_BITWIDTH-1:0] SAT_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
  localparam logic [ACC_BITWIDTH-1:0] SAT_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};
`endif

  state_t                  state;
  logic [ACC_BITWIDTH-1:0] acc;
  logic [15:0]             cnt;
  logic                    ovf_sticky;

  logic                    accept;
  logic [ACC_BITWIDTH-1:0] ext;
  logic [ACC_BITWIDTH-1:0] sum_wrap;
  logic [ACC_BITWIDTH-1:0] add_sum;
  logic                    add_ovf;
  logic [ACC_BITWIDTH-1:0] acc_after;
  logic [15:0]             cnt_after;
  logic                    sticky_after;
  logic                    close_win;

  // Input acceptance depends only on the state, never on out_ready.
  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;

  // Compute the next accumulator and count, and decide whether this cycle closes the window.
  always_comb begin
    ext          = {{(ACC_BITWIDTH-OP_BITWIDTH){in_data[OP_BITWIDTH-1]}}, in_data};
    sum_wrap     = acc + ext;
    add_sum      = sum_wrap;
    add_ovf      = 1'b0;
`ifdef CONF_INT_ADD_RESULT_ACC_SAT_EN
    // Overflow happens when both operands have the same sign and the result sign differs.
    add_ovf = (acc[ACC_BITWIDTH-1] == ext[ACC_BITWIDTH-1]) &&
              (sum_wrap[ACC_BITWIDTH-1] != acc[ACC_BITWIDTH-1]);
    if (add_ovf) begin
      add_sum = acc[ACC_BITWIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    acc_after    = acc;
    cnt_after    = cnt;
    sticky_after = ovf_sticky;
    if (accept) begin
      acc_after    = add_sum;
      cnt_after    = cnt + 16'd1;
      sticky_after = ovf_sticky | add_ovf;
    end
    // A flush counts a sample accepted in the same cycle. An empty flush is ignored.
    close_win = (state == ACC) &&
                ((accept && (cnt_after == WIN)) || (flush && (cnt_after != 16'd0)));
  end

  // Control and datapath registers. Reset discards any partial or pending window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          acc        <= acc_after;
          cnt        <= cnt_after;
          ovf_sticky <= sticky_after;
          if (close_win) begin
            out_sum   <= acc_after;
            out_count <= cnt_after;
            out_ovf   <= sticky_after;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Results stay frozen until the consumer takes them. Then a fresh window starts.
          if (out_ready) begin
            out_valid  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            state      <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
